// File: rtl/fdiv_issue.sv
// fdiv_issue: credit-based issue control for a fixed-latency divide datapath,
// with an in-order result buffer that can never overflow.
module fdiv_issue #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_y,
  input  logic        dp_error,
  input  logic        dp_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_error,
  output logic        out_overflow,
  output logic        busy,
  output logic [7:0]  err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LAT-1:0] v;
  logic [33:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [3:0]     inflight;
  logic           fire, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + 4'(v[i]);
  end

  // every in-flight op already owns a buffer slot; a same-cycle pop frees nothing yet
  assign in_ready  = rst_n && ((6'(count) + 6'(inflight)) < 6'(DEPTH));
  assign fire      = in_valid && in_ready;
  assign dp_a      = fire ? in_a : '0;
  assign dp_b      = fire ? in_b : '0;
  assign push      = v[LAT-1];
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign {out_y, out_error, out_overflow} = out_valid ? mem[rd_ptr] : 34'h0;
  assign busy      = out_valid || (v != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      v <= {v[LAT-2:0], fire};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      if (push && dp_error && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dp_y, dp_error, dp_overflow};
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL));
endmodule

// File: tb/tb_fdiv_issue.sv
// tb_fdiv_issue: directed scenarios for fdiv_issue against a two-stage
// datapath model (exact quotient for equal-mantissa operands).
module tb_fdiv_issue;
  logic        clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_error, out_overflow, busy;
  logic [31:0] dp_a, dp_b, dp_y, out_y;
  logic        dp_error, dp_overflow;
  logic [7:0]  err_cnt;
  logic [33:0] s1 = '0, s2 = '0;
  int tests = 0, fails = 0;

  fdiv_issue #(.LAT(2), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .dp_a(dp_a), .dp_b(dp_b),
    .dp_y(dp_y), .dp_error(dp_error), .dp_overflow(dp_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_error(out_error), .out_overflow(out_overflow),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // datapath model: error on negative or zero divisor, overflow on negative dividend
  function automatic logic [33:0] dpm(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] e;
    e = a[30:23] - b[30:23] + 8'd127;
    return {a[31] ^ b[31], e, a[22:0] - b[22:0], b[31] | (b[30:0] == 31'h0), a[31]};
  endfunction

  always @(posedge clk) begin
    s1 <= dpm(dp_a, dp_b);
    s2 <= s1;
  end
  assign {dp_y, dp_error, dp_overflow} = s2;

  function automatic logic [63:0] op(input int k, input bit all_err);
    logic [31:0] a, b;
    a = {k[1], 8'(100 + k % 50), 23'(k * 3)};
    b = {all_err | k[0], 8'(90 + k % 7), 23'h0};
    return {a, b};
  endfunction

  task automatic test_reset();
    in_valid = 1; in_a = 32'h40400000; in_b = 32'h3FC00000;
    #2 rst_n = 0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_valid_busy got %b/%b expected 0/0", out_valid, busy); end
    tests++; if ({out_y, out_error, out_overflow} !== 34'h0) begin fails++; $display("FAIL reset_out got %h expected 0", {out_y, out_error, out_overflow}); end
    tests++; if (dp_a !== 32'h0 || dp_b !== 32'h0) begin fails++; $display("FAIL reset_dp got %h/%h expected 0/0", dp_a, dp_b); end
    tests++; if (err_cnt !== 8'h0) begin fails++; $display("FAIL reset_err_cnt got %h expected 00", err_cnt); end
    @(negedge clk);
    in_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_single();
    in_valid = 1; in_a = 32'h40400000; in_b = 32'h3FC00000; out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL first_ready got %b expected 1", in_ready); end
    tests++; if (dp_a !== 32'h40400000 || dp_b !== 32'h3FC00000) begin fails++; $display("FAIL dp_pass got %h/%h expected 40400000/3fc00000", dp_a, dp_b); end
    @(negedge clk);
    in_valid = 0;
    #1;
    tests++; if (dp_a !== 32'h0 || busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL single_e0 got dp_a=%h busy=%b ov=%b expected 0/1/0", dp_a, busy, out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_e1 got out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_y !== 32'h40000000 || out_error !== 1'b0 || out_overflow !== 1'b0)
      begin fails++; $display("FAIL single_result got v=%b y=%h e=%b o=%b expected 1/40000000/0/0", out_valid, out_y, out_error, out_overflow); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_y !== 32'h0) begin fails++; $display("FAIL single_drain got v=%b busy=%b y=%h expected 0/0/0", out_valid, busy, out_y); end
    out_ready = 0;
  endtask

  task automatic test_stall_fill();
    int fires = 0;
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1; in_a = {1'b0, 8'(130 + fires), 23'h0}; in_b = 32'h3F800000;
      #1;
      if (in_ready) fires++;
    end
    @(negedge clk);
    in_valid = 0;
    #1;
    tests++; if (fires !== 4) begin fails++; $display("FAIL fill_fires got %0d expected 4", fires); end
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL fill_full got rdy=%b ov=%b expected 0/1", in_ready, out_valid); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({out_y, out_error, out_overflow} !== {1'b0, 8'(130 + i), 23'h0, 2'b00})
        begin fails++; $display("FAIL fill_order[%0d] got %h expected %h", i, out_y, {1'b0, 8'(130 + i), 23'h0}); end
      @(negedge clk);
      #1;
    end
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL fill_drain got ov=%b busy=%b expected 0/0", out_valid, busy); end
    out_ready = 0;
  endtask

  task automatic test_stream(input string name, input int n, input bit rnd, input bit all_err);
    logic [33:0] q[$];
    logic [33:0] exp_v;
    logic [63:0] o;
    int issued = 0, got = 0, cyc = 0, stalls = 0;
    while (got < n && cyc < n * 10 + 50) begin
      @(negedge clk);
      o = op(issued, all_err);
      in_valid = issued < n;
      {in_a, in_b} = o;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL %s extra result got %h expected none", name, out_y); end
        else begin
          exp_v = q.pop_front();
          if ({out_y, out_error, out_overflow} !== exp_v)
            begin fails++; $display("FAIL %s result[%0d] got %h expected %h", name, got, {out_y, out_error, out_overflow}, exp_v); end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(dpm(in_a, in_b)); issued++; end
      else if (in_valid) stalls++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #1;
    tests++; if (got !== n) begin fails++; $display("FAIL %s count got %0d expected %0d", name, got, n); end
    if (!rnd) begin
      tests++; if (stalls !== 0) begin fails++; $display("FAIL %s throughput got %0d stalls expected 0", name, stalls); end
    end
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL %s idle got busy=%b ov=%b expected 0/0", name, busy, out_valid); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    in_valid = 1; in_a = 32'h40400000; in_b = 32'h3FC00000; out_ready = 1;
    @(negedge clk);
    in_valid = 0; rst_n = 0;
    #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || err_cnt !== 8'h0) begin fails++; $display("FAIL midrst got busy=%b rdy=%b err=%h expected 0/0/00", busy, in_ready, err_cnt); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_stale[%0d] got ov=%b busy=%b expected 0/0", i, out_valid, busy); end
    end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_fill();
    test_stream("back_to_back", 12, 0, 0);
    tests++; if (err_cnt !== 8'd6) begin fails++; $display("FAIL err_cnt_b2b got %0d expected 6", err_cnt); end
    test_stream("wrap", 10, 1, 0);
    tests++; if (err_cnt !== 8'd11) begin fails++; $display("FAIL err_cnt_wrap got %0d expected 11", err_cnt); end
    test_reset_midflight();
    test_stream("errors", 300, 0, 1);
    tests++; if (err_cnt !== 8'hFF) begin fails++; $display("FAIL err_cnt_sat got %h expected ff", err_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
